usb_setup_decoder: RTL
======================

USB_SETUP_DECODER -- requirements
Module: usb_setup_decoder

Interface
REQ-001 SHALL have parameter SETUP_LEN, default 8, which is the number of bytes in a SETUP data stage.
REQ-002 SHALL have parameter CNT_W, default 4, which is the width of the byte counter; it must satisfy 2^CNT_W > SETUP_LEN.
REQ-003 SHALL have port clk, input, 1 bit: the 48 MHz system clock; all logic runs on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have the following inputs from the USB core, all on clk:
- usb_rst, 1 bit: bus reset from the host; acts as a synchronous clear.
- transaction_active, 1 bit: high for the whole token/data/handshake transaction.
- setup, 1 bit: the current transaction is a SETUP.
- data_strobe, 1 bit: single-cycle pulse with each received byte.
- data_out, 8 bits: received byte, qualified by data_strobe.
- success, 1 bit: pulse when the data packet CRC is valid.
REQ-006 SHALL have port req_ack, input, 1 bit: the consumer has taken the request.
REQ-007 SHALL have the following decoded-request outputs:
- req_valid, 1 bit: a decoded request is held.
- bm_request_type, 8 bits.
- b_request, 8 bits.
- w_value, 16 bits.
- w_index, 16 bits.
- w_length, 16 bits.
REQ-008 SHALL have the following derived outputs:
- req_dir_in, 1 bit: equals bm_request_type[7].
- req_type, 2 bits: equals bm_request_type[6:5].
- req_recipient, 5 bits: equals bm_request_type[4:0].
REQ-009 SHALL have port req_error, output, 1 bit: single-cycle pulse when a SETUP data stage is discarded.

Function
REQ-010 SHALL implement the FSM states IDLE, COLLECT, CHECK and HOLD.
REQ-011 SHALL leave IDLE or HOLD for COLLECT on the rising edge of transaction_active when setup=1. At that transition it clears the byte counter, the overflow flag and the success flag, and deasserts req_valid in the same cycle. A new SETUP always overrides an unacknowledged request.
REQ-012 In COLLECT, SHALL write data_out into byte slot [count] on each data_strobe while count<SETUP_LEN, and increment count.
REQ-013 SHALL, on any strobe with count==SETUP_LEN, set the overflow flag, leave the stored bytes unchanged and saturate count.
REQ-014 In COLLECT, SHALL record success in a sticky flag.
REQ-015 SHALL move from COLLECT to CHECK on the first cycle transaction_active=0.
REQ-016 In CHECK (one cycle), SHALL go to HOLD when the success flag=1, count==SETUP_LEN and overflow=0. Otherwise it pulses req_error for one cycle and returns to IDLE.
REQ-017 SHALL assert req_valid on the cycle HOLD is entered, i.e. 2 clk after the falling edge of transaction_active is sampled.
REQ-018 SHALL assemble all 16-bit fields little-endian:
- w_value = {byte3, byte2}
- w_index = {byte5, byte4}
- w_length = {byte7, byte6}
REQ-019 In HOLD, SHALL hold the outputs stable until req_ack=1. On req_ack it deasserts req_valid in the next cycle and returns to IDLE.
REQ-020 SHALL ignore req_ack when req_valid=0.
REQ-021 SHALL ignore non-SETUP transactions (setup=0) entirely, including their data_strobe pulses.
REQ-022 SHALL give priority to the new SETUP start when req_ack and a new SETUP start occur in the same cycle.
REQ-023 SHALL update the output fields only on entry to HOLD; bytes collected during COLLECT are not visible before then.

Reset
REQ-024 SHALL, on rst=0 or usb_rst=1 at a rising clk edge, return to IDLE with count, flags, byte slots and all output registers at 0. req_valid=0 and req_error=0.
REQ-025 SHALL abandon any in-progress collection on a reset mid-COLLECT, with no req_error pulse.

Structure
REQ-026 SHALL place the following in shared package usb_pkg:
- the FSM state encoding;
- SETUP_LEN;
- bRequest constants GET_STATUS=8'h00, SET_ADDRESS=8'h05, GET_DESCRIPTOR=8'h06, VENDOR_30=8'h30, VENDOR_31=8'h31;
- descriptor type constants DEVICE=1, CONFIGURATION=2, STRING=3.
REQ-027 SHALL be implemented as a single module with no sub-module; the 8-byte capture store is an inline register array.

Verification
REQ-028 Good SETUP: send bytes 80 06 00 01 00 00 12 00 with success, then transaction_active falls. Required: req_valid=1 two cycles later, b_request=06, w_value=0100, w_length=0012, req_dir_in=1, req_type=0, req_recipient=0.
REQ-029 Bad CRC: send 8 bytes with no success pulse. Required: one-cycle req_error pulse, req_valid stays 0, FSM in IDLE.
REQ-030 Length errors:
- 7 bytes then end: req_error.
- 9 bytes then end: req_error, and byte slot 0 unchanged from the first byte.
REQ-031 Override: good SETUP (SET_ADDRESS, w_value=0005), left unacked, followed by a new SETUP 00 09 01 00 00 00 00 00. Required: req_valid drops at the new start, then reasserts with b_request=09, w_value=0001.
REQ-032 Handshake and filtering:
- req_ack pulse: req_valid=0 next cycle.
- OUT data-stage bytes (setup=0): no change to the outputs.
REQ-033 Reset: rst=0 asserted mid-COLLECT after 4 bytes. Required: all outputs 0 next cycle, no req_error; a subsequent good SETUP decodes correctly.

Source files
------------

// File: rtl/usb_pkg.sv
// ---------------------------------------------------------------------------
// usb_pkg
// Shared definitions for the USB control-endpoint logic:
//   - SETUP_LEN     : number of bytes in a SETUP data stage
//   - state_e       : setup-decoder FSM state encoding
//   - bRequest codes: standard and vendor request numbers
//   - descriptor type codes used in wValue[15:8] of GET_DESCRIPTOR
// ---------------------------------------------------------------------------
package usb_pkg;

    localparam int SETUP_LEN = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHECK   = 2'd2,
        HOLD    = 2'd3
    } state_e;

    // bRequest values
    localparam logic [7:0] GET_STATUS     = 8'h00;
    localparam logic [7:0] SET_ADDRESS    = 8'h05;
    localparam logic [7:0] GET_DESCRIPTOR = 8'h06;
    localparam logic [7:0] VENDOR_30      = 8'h30;
    localparam logic [7:0] VENDOR_31      = 8'h31;

    // Descriptor types
    localparam logic [7:0] DEVICE         = 8'd1;
    localparam logic [7:0] CONFIGURATION  = 8'd2;
    localparam logic [7:0] STRING         = 8'd3;

endpackage

// File: rtl/usb_setup_decoder.sv
// ---------------------------------------------------------------------------
// usb_setup_decoder
// Captures the 8-byte data stage of a USB SETUP transaction, validates it
// (CRC success seen, exact byte count) and presents the decoded request
// until the consumer acknowledges it.
//
// Ports
//   clk                : system clock, rising edge
//   rst                : synchronous reset, active low
//   usb_rst            : bus reset from host, synchronous clear
//   transaction_active : high for the whole token/data/handshake transaction
//   setup              : current transaction is a SETUP
//   data_strobe        : one-cycle pulse per received byte
//   data_out[7:0]      : received byte, qualified by data_strobe
//   success            : pulse when the data packet CRC is good
//   req_ack            : consumer has taken the request
//   req_valid          : decoded request held
//   bm_request_type, b_request, w_value, w_index, w_length : request fields
//   req_dir_in, req_type, req_recipient : fields of bm_request_type
//   req_error          : one-cycle pulse when a SETUP stage is discarded
// ---------------------------------------------------------------------------
module usb_setup_decoder
    import usb_pkg::*;
#(
    parameter int SETUP_LEN = usb_pkg::SETUP_LEN,
    parameter int CNT_W     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        usb_rst,
    input  logic        transaction_active,
    input  logic        setup,
    input  logic        data_strobe,
    input  logic [7:0]  data_out,
    input  logic        success,
    input  logic        req_ack,
    output logic        req_valid,
    output logic [7:0]  bm_request_type,
    output logic [7:0]  b_request,
    output logic [15:0] w_value,
    output logic [15:0] w_index,
    output logic [15:0] w_length,
    output logic        req_dir_in,
    output logic [1:0]  req_type,
    output logic [4:0]  req_recipient,
    output logic        req_error
);

    localparam int                IDX_W = $clog2(SETUP_LEN);
    localparam logic [CNT_W-1:0]  LEN_C = CNT_W'(SETUP_LEN);

    state_e             r_state;
    state_e             w_state_nxt;

    logic               r_ta_d;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;
    logic               r_success;
    logic [7:0]         r_bytes [SETUP_LEN];

    logic               r_req_valid;
    logic               r_req_error;
    logic [7:0]         r_bm;
    logic [7:0]         r_breq;
    logic [15:0]        r_wvalue;
    logic [15:0]        r_windex;
    logic [15:0]        r_wlength;

    logic               w_clear;
    logic               w_start;
    logic               w_setup_ok;
    logic [IDX_W-1:0]   w_idx;

    assign w_clear    = !rst || usb_rst;
    // SETUP start: rising edge of transaction_active while setup is flagged
    assign w_start    = transaction_active && !r_ta_d && setup;
    assign w_setup_ok = r_success && (r_count == LEN_C) && !r_overflow;
    assign w_idx      = r_count[IDX_W-1:0];

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (w_clear) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = COLLECT;
            COLLECT: if (!transaction_active) w_state_nxt = CHECK;
            CHECK:   w_state_nxt = w_setup_ok ? HOLD : IDLE;
            // A new SETUP wins over an acknowledge in the same cycle
            HOLD: begin
                if (w_start)      w_state_nxt = COLLECT;
                else if (req_ack) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (w_clear) begin
            // Track the live level so a transaction still in flight when
            // reset releases is not mistaken for a fresh SETUP start.
            r_ta_d      <= transaction_active;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_success   <= 1'b0;
            r_req_valid <= 1'b0;
            r_req_error <= 1'b0;
            r_bm        <= '0;
            r_breq      <= '0;
            r_wvalue    <= '0;
            r_windex    <= '0;
            r_wlength   <= '0;
            for (int i = 0; i < SETUP_LEN; i++) r_bytes[i] <= '0;
        end else begin
            r_ta_d      <= transaction_active;
            r_req_error <= 1'b0;
            case (r_state)
                IDLE, HOLD: begin
                    if (w_start) begin
                        r_count     <= '0;
                        r_overflow  <= 1'b0;
                        r_success   <= 1'b0;
                        r_req_valid <= 1'b0;
                    end else if (r_state == HOLD && req_ack) begin
                        r_req_valid <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (data_strobe) begin
                        if (r_count < LEN_C) begin
                            r_bytes[w_idx] <= data_out;
                            r_count        <= r_count + CNT_W'(1);
                        end else begin
                            // Extra byte: flag it, keep stored bytes and count
                            r_overflow <= 1'b1;
                        end
                    end
                    if (success) r_success <= 1'b1;
                end
                CHECK: begin
                    if (w_setup_ok) begin
                        // Fields only become visible on entry to HOLD
                        r_req_valid <= 1'b1;
                        r_bm        <= r_bytes[0];
                        r_breq      <= r_bytes[1];
                        r_wvalue    <= {r_bytes[3], r_bytes[2]};
                        r_windex    <= {r_bytes[5], r_bytes[4]};
                        r_wlength   <= {r_bytes[7], r_bytes[6]};
                    end else begin
                        r_req_error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_valid       = r_req_valid;
    assign req_error       = r_req_error;
    assign bm_request_type = r_bm;
    assign b_request       = r_breq;
    assign w_value         = r_wvalue;
    assign w_index         = r_windex;
    assign w_length        = r_wlength;
    assign req_dir_in      = r_bm[7];
    assign req_type        = r_bm[6:5];
    assign req_recipient   = r_bm[4:0];

endmodule
